// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: state encoding, NOP word, reset PC
// and the IF/ID payload layout.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned IFID_W = 1 + 3 * XLEN;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcPlus4;
    logic [XLEN-1:0] instr;
  } ifid_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush clears valid and forces a NOP while keeping
// the PC fields from the last real load; otherwise load or hold.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  load_i,
  input  logic  flush_i,
  input  ifid_t d_i,
  output ifid_t q_o
);

  ifid_t q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q <= '0;
    end else if (flush_i) begin
      q.valid <= 1'b0;
      q.instr <= NOP_INSTR;
    end else if (load_i) begin
      q <= d_i;
    end
  end

  assign q_o = q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem request handshake, stall buffer and the
// kill/redirect path for branches that land while a request is outstanding.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_next_i,
  input  logic        branch_taken_i,
  input  logic        stall_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_pc_plus4_o,
  output logic [31:0] ifid_instr_o
);

  fetch_state_e state, stateD;
  logic [31:0]  pcQ, pcD;
  logic [31:0]  bufQ, bufD;
  logic [31:0]  redirQ, redirD;
  logic         killQ, killD;
  logic         ifLoad, ifFlush;
  ifid_t        ifD, ifQ;
  logic [31:0]  pcPlus4;

  assign pcPlus4 = pcQ + 32'd4;

  always_comb begin
    stateD  = state;
    pcD     = pcQ;
    bufD    = bufQ;
    redirD  = redirQ;
    killD   = killQ;
    ifLoad  = 1'b0;
    ifFlush = 1'b0;
    ifD     = '{valid: 1'b1, pc: pcQ, pcPlus4: pcPlus4, instr: imem_rdata_i};
    case (state)
      FETCH_IDLE: stateD = FETCH_REQ;
      FETCH_REQ: begin
        if (branch_taken_i) begin
          ifFlush = 1'b1;
          if (imem_ready_i) begin
            pcD   = pc_next_i;
            killD = 1'b0;
          end else begin
            // Request stays outstanding at the old PC; its response is dropped later.
            redirD = pc_next_i;
            killD  = 1'b1;
          end
        end else if (imem_ready_i && killQ) begin
          pcD     = redirQ;
          killD   = 1'b0;
          ifFlush = !stall_i;
        end else if (imem_ready_i && stall_i) begin
          bufD   = imem_rdata_i;
          stateD = FETCH_HOLD;
        end else if (imem_ready_i) begin
          ifLoad = 1'b1;
          pcD    = pc_next_i;
        end else begin
          ifFlush = !stall_i;
        end
      end
      FETCH_HOLD: begin
        if (branch_taken_i) begin
          ifFlush = 1'b1;
          pcD     = pc_next_i;
          stateD  = FETCH_REQ;
        end else if (!stall_i) begin
          ifLoad    = 1'b1;
          ifD.instr = bufQ;
          pcD       = pc_next_i;
          stateD    = FETCH_REQ;
        end
      end
      default: stateD = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= FETCH_IDLE;
      pcQ    <= RESET_PC;
      bufQ   <= '0;
      redirQ <= '0;
      killQ  <= 1'b0;
    end else begin
      state  <= stateD;
      pcQ    <= pcD;
      bufQ   <= bufD;
      redirQ <= redirD;
      killQ  <= killD;
    end
  end

  if_id_reg ifIdReg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (ifLoad),
    .flush_i (ifFlush),
    .d_i     (ifD),
    .q_o     (ifQ)
  );

  assign pc_o            = pcQ;
  assign pc_plus4_o      = pcPlus4;
  assign imem_req_o      = (state == FETCH_REQ);
  assign imem_addr_o     = pcQ;
  assign ifid_valid_o    = ifQ.valid;
  assign ifid_pc_o       = ifQ.pc;
  assign ifid_pc_plus4_o = ifQ.pcPlus4;
  assign ifid_instr_o    = ifQ.instr;

endmodule
